// File: rtl/fbdev_vtg_pkg.sv
// Shared 720p60 timing constants, FSM state type and sizing helpers for the fbdev
// video timing generator.
package fbdev_vtg_pkg;

    localparam int unsigned VTG_H_ACTIVE = 32'd1280;
    localparam int unsigned VTG_H_FP     = 32'd110;
    localparam int unsigned VTG_H_SYNC   = 32'd40;
    localparam int unsigned VTG_H_BP     = 32'd220;
    localparam int unsigned VTG_V_ACTIVE = 32'd720;
    localparam int unsigned VTG_V_FP     = 32'd5;
    localparam int unsigned VTG_V_SYNC   = 32'd5;
    localparam int unsigned VTG_V_BP     = 32'd20;
    localparam int unsigned VTG_PREFETCH = 32'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        RUN   = 2'd2
    } vtg_state_t;

    function automatic int unsigned vtg_total(input int unsigned act_len,
                                              input int unsigned fp_len,
                                              input int unsigned sync_len,
                                              input int unsigned bp_len);
        return act_len + fp_len + sync_len + bp_len;
    endfunction

    function automatic int unsigned vtg_width(input int unsigned n);
        return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/fbdev_sync2.sv
// Two-flop synchronizer for single-bit control signals crossing into clk_i.
module fbdev_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_r;

    // Two-stage capture; first stage may go metastable, second stage settles it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_r <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_r <= d_i;
            q_o    <= meta_r;
        end
    end

endmodule

// File: rtl/fbdev_vtg.sv
// Video timing generator: hsync/vsync/de, pixel coordinates and an early pixel request,
// held idle until PLL lock and blanking the first frame after each lock.
module fbdev_vtg
    import fbdev_vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VTG_H_ACTIVE,
    parameter int unsigned H_FP     = VTG_H_FP,
    parameter int unsigned H_SYNC   = VTG_H_SYNC,
    parameter int unsigned H_BP     = VTG_H_BP,
    parameter int unsigned V_ACTIVE = VTG_V_ACTIVE,
    parameter int unsigned V_FP     = VTG_V_FP,
    parameter int unsigned V_SYNC   = VTG_V_SYNC,
    parameter int unsigned V_BP     = VTG_V_BP,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned PREFETCH = VTG_PREFETCH
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              locked_i,
    output logic                              hsync_o,
    output logic                              vsync_o,
    output logic                              de_o,
    output logic [vtg_width(H_ACTIVE)-1:0]    x_o,
    output logic [vtg_width(V_ACTIVE)-1:0]    y_o,
    output logic                              req_o,
    output logic                              sof_o
);

    localparam int unsigned H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = vtg_width(H_TOTAL);
    localparam int unsigned VW      = vtg_width(V_TOTAL);
    localparam int unsigned XW      = vtg_width(H_ACTIVE);
    localparam int unsigned YW      = vtg_width(V_ACTIVE);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 32'd1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 32'd1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW:0]   H_TOTAL_W  = (HW+1)'(H_TOTAL);
    // Outputs are registered one cycle after the counters, so a lookahead of PREFETCH
    // positions yields a request that leads de_o by exactly PREFETCH cycles.
    localparam logic [HW:0]   LA_STEP    = (HW+1)'(PREFETCH);

    logic              rst_int_n_s;
    logic              run_s;
    vtg_state_t        state_r, state_nxt_s;
    logic [HW-1:0]     hcnt_r, hcnt_nxt_s;
    logic [VW-1:0]     vcnt_r, vcnt_nxt_s;
    logic              h_last_s, v_last_s, frame_end_s;
    logic [HW:0]       la_sum_s;
    logic              la_hwrap_s;
    logic [HW-1:0]     la_h_s;
    logic [VW-1:0]     la_v_s;
    logic              live_s, req_en_s;
    logic              hsync_nxt_s, vsync_nxt_s, de_nxt_s, req_nxt_s, sof_nxt_s;
    logic [XW-1:0]     x_nxt_s;
    logic [YW-1:0]     y_nxt_s;

    fbdev_sync2 u_rst_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (1'b1),
        .q_o    (rst_int_n_s)
    );

    fbdev_sync2 u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_int_n_s),
        .d_i    (locked_i),
        .q_o    (run_s)
    );

    assign h_last_s    = (hcnt_r == H_LAST);
    assign v_last_s    = (vcnt_r == V_LAST);
    assign frame_end_s = h_last_s && v_last_s;

    // Next state and counter advance; losing lock clears everything on the same edge
    always_comb begin
        state_nxt_s = state_r;
        hcnt_nxt_s  = hcnt_r;
        vcnt_nxt_s  = vcnt_r;
        if (!run_s) begin
            state_nxt_s = IDLE;
            hcnt_nxt_s  = {HW{1'b0}};
            vcnt_nxt_s  = {VW{1'b0}};
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = BLANK;
                BLANK:   state_nxt_s = frame_end_s ? RUN : BLANK;
                RUN:     state_nxt_s = RUN;
                default: state_nxt_s = IDLE;
            endcase
            if (state_r == IDLE) begin
                hcnt_nxt_s = hcnt_r;
                vcnt_nxt_s = vcnt_r;
            end else if (h_last_s) begin
                hcnt_nxt_s = {HW{1'b0}};
                vcnt_nxt_s = v_last_s ? {VW{1'b0}} : (vcnt_r + VW'(1'b1));
            end else begin
                hcnt_nxt_s = hcnt_r + HW'(1'b1);
                vcnt_nxt_s = vcnt_r;
            end
        end
    end

    // FSM state and position counters
    always_ff @(posedge clk_i or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r <= IDLE;
            hcnt_r  <= {HW{1'b0}};
            vcnt_r  <= {VW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            hcnt_r  <= hcnt_nxt_s;
            vcnt_r  <= vcnt_nxt_s;
        end
    end

    // Lookahead position with a single conditional subtract and carry into the line
    always_comb begin
        la_sum_s   = {1'b0, hcnt_r} + LA_STEP;
        la_hwrap_s = (la_sum_s >= H_TOTAL_W);
        if (la_hwrap_s) begin
            la_h_s = HW'(la_sum_s - H_TOTAL_W);
            la_v_s = v_last_s ? {VW{1'b0}} : (vcnt_r + VW'(1'b1));
        end else begin
            la_h_s = la_sum_s[HW-1:0];
            la_v_s = vcnt_r;
        end
    end

    // Requests in BLANK only when they reach into the first line of the coming RUN frame
    assign live_s   = run_s && (state_r != IDLE);
    assign req_en_s = (state_r == RUN) ||
                      ((state_r == BLANK) && la_hwrap_s && v_last_s);

    // Output decode from the current counter state
    always_comb begin
        hsync_nxt_s = ~H_POL;
        vsync_nxt_s = ~V_POL;
        de_nxt_s    = 1'b0;
        req_nxt_s   = 1'b0;
        sof_nxt_s   = 1'b0;
        x_nxt_s     = {XW{1'b0}};
        y_nxt_s     = {YW{1'b0}};
        if (live_s) begin
            if ((hcnt_r >= H_SYNC_BEG) && (hcnt_r < H_SYNC_END)) begin
                hsync_nxt_s = H_POL;
            end else begin
                hsync_nxt_s = ~H_POL;
            end
            if ((vcnt_r >= V_SYNC_BEG) && (vcnt_r < V_SYNC_END)) begin
                vsync_nxt_s = V_POL;
            end else begin
                vsync_nxt_s = ~V_POL;
            end
            if ((state_r == RUN) && (hcnt_r < H_ACT) && (vcnt_r < V_ACT)) begin
                de_nxt_s = 1'b1;
                x_nxt_s  = hcnt_r[XW-1:0];
                y_nxt_s  = vcnt_r[YW-1:0];
            end else begin
                de_nxt_s = 1'b0;
            end
            if (req_en_s && (la_h_s < H_ACT) && (la_v_s < V_ACT)) begin
                req_nxt_s = 1'b1;
                sof_nxt_s = (la_h_s == {HW{1'b0}}) && (la_v_s == {VW{1'b0}});
            end else begin
                req_nxt_s = 1'b0;
            end
        end else begin
            de_nxt_s = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_i or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            hsync_o <= ~H_POL;
            vsync_o <= ~V_POL;
            de_o    <= 1'b0;
            req_o   <= 1'b0;
            sof_o   <= 1'b0;
            x_o     <= {XW{1'b0}};
            y_o     <= {YW{1'b0}};
        end else begin
            hsync_o <= hsync_nxt_s;
            vsync_o <= vsync_nxt_s;
            de_o    <= de_nxt_s;
            req_o   <= req_nxt_s;
            sof_o   <= sof_nxt_s;
            x_o     <= x_nxt_s;
            y_o     <= y_nxt_s;
        end
    end

endmodule
